// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared state encoding and digit helpers for bin_to_bcd_hs.
// Revision: 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ABS     = 3'd1;
  localparam logic [2:0] c_CONVERT = 3'd2;
  localparam logic [2:0] c_COUNT   = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  function automatic logic [3:0] bcd_adj3(input logic [3:0] digit);
    return (digit > 4'd4) ? digit + 4'd3 : digit;
  endfunction

  function automatic int digits_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : bcd_shift_stage
// Brief   : One double-dabble step: add-3 on every digit, then 1-bit shift.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_shift_stage
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 24,
  parameter int DECIMAL_DIGITS = 8
) (
  input  logic [DECIMAL_DIGITS*4-1:0] i_bcd,
  input  logic [INPUT_WIDTH-1:0]      i_mag,
  output logic [DECIMAL_DIGITS*4-1:0] o_bcd,
  output logic [INPUT_WIDTH-1:0]      o_mag,
  output logic                        o_carry
);

  logic [DECIMAL_DIGITS*4-1:0] w_adj;

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
    assign w_adj[g*4 +: 4] = bcd_adj3(i_bcd[g*4 +: 4]);
  end

  // The bit leaving the top digit is the 10^DECIMAL_DIGITS overflow indicator.
  assign {o_carry, o_bcd, o_mag} = {w_adj, i_mag, 1'b0};

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_hs.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_hs
// Brief   : Handshaked signed/unsigned binary-to-BCD converter with digit count.
// Revision: 1.0 - initial release
// ============================================================================
module bin_to_bcd_hs
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 24,
  parameter int DECIMAL_DIGITS = 8,
  parameter int SIGNED_MODE    = 1
) (
  input  logic                                    CLK,
  input  logic                                    RST_N,
  input  logic [INPUT_WIDTH-1:0]                  i_bin,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  output logic [DECIMAL_DIGITS*4-1:0]             o_bcd,
  output logic                                    o_sign,
  output logic                                    o_ovf,
  output logic [digits_width(DECIMAL_DIGITS)-1:0] o_ndigits,
  output logic                                    o_valid,
  input  logic                                    i_ready
);

  localparam int c_ND_W  = digits_width(DECIMAL_DIGITS);
  localparam int c_CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(INPUT_WIDTH - 1);
  localparam logic [c_ND_W-1:0]  c_DIG_TOP  = c_ND_W'(DECIMAL_DIGITS - 1);
  localparam logic [c_ND_W-1:0]  c_DIG_ALL  = c_ND_W'(DECIMAL_DIGITS);

  logic [2:0]                  r_state;
  logic [INPUT_WIDTH-1:0]      r_mag;
  logic [DECIMAL_DIGITS*4-1:0] r_bcd;
  logic                        r_sign;
  logic                        r_ovf;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_ND_W-1:0]           r_dig;
  logic                        r_found;
  logic [c_ND_W-1:0]           r_ndigits;
  logic                        r_valid;

  logic [DECIMAL_DIGITS*4-1:0] w_bcd_nxt;
  logic [INPUT_WIDTH-1:0]      w_mag_nxt;
  logic                        w_carry;
  logic                        w_neg;
  logic [3:0]                  w_digit;

  bcd_shift_stage #(
    .INPUT_WIDTH    (INPUT_WIDTH),
    .DECIMAL_DIGITS (DECIMAL_DIGITS)
  ) u_stage (
    .i_bcd   (r_bcd),
    .i_mag   (r_mag),
    .o_bcd   (w_bcd_nxt),
    .o_mag   (w_mag_nxt),
    .o_carry (w_carry)
  );

  assign w_neg   = (SIGNED_MODE != 0) && r_mag[INPUT_WIDTH-1];
  assign w_digit = r_bcd[r_dig*4 +: 4];

  assign o_ready   = (r_state == c_IDLE) && RST_N;
  assign o_bcd     = r_bcd;
  assign o_sign    = r_sign;
  assign o_ovf     = r_ovf;
  assign o_ndigits = r_ndigits;
  assign o_valid   = r_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= c_IDLE;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_dig     <= '0;
      r_found   <= 1'b0;
      r_ndigits <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_valid) begin
            r_mag   <= i_bin;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_sign  <= 1'b0;
            r_state <= c_ABS;
          end
        end
        c_ABS: begin
          // Negating the most-negative value wraps back to 2^(W-1), which is
          // exactly the right unsigned magnitude.
          r_sign  <= w_neg;
          r_mag   <= w_neg ? (~r_mag + 1'b1) : r_mag;
          r_cnt   <= '0;
          r_state <= c_CONVERT;
        end
        c_CONVERT: begin
          r_bcd <= w_bcd_nxt;
          r_mag <= w_mag_nxt;
          r_ovf <= r_ovf | w_carry;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_dig     <= c_DIG_TOP;
            r_found   <= 1'b0;
            r_ndigits <= c_ND_W'(1);
            r_state   <= c_COUNT;
          end
        end
        c_COUNT: begin
          if (!r_found && (w_digit != 4'd0)) begin
            r_found   <= 1'b1;
            r_ndigits <= r_dig + 1'b1;
          end
          if (r_dig == '0) begin
            // Later assignments override the scan result on the final step.
            if (r_ovf) r_ndigits <= c_DIG_ALL;
            if (!r_ovf && !r_found && (w_digit == 4'd0)) r_sign <= 1'b0;
            r_valid <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_dig <= r_dig - 1'b1;
          end
        end
        c_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_hs.md
Name: bin_to_bcd_hs

Overview:
Parametrised, handshaked binary-to-BCD converter for the calculator display path. It is the successor to the single-mode converter.
- Accepts signed or unsigned binary on a valid/ready input channel.
- Converts the magnitude with one double-dabble shift per cycle, adjusting all digits in parallel.
- Reports sign, overflow and significant-digit count for leading-zero blanking.
- Holds the result until the display side takes it.

Parameters:
INPUT_WIDTH, 24, width of i_bin (>=2)
DECIMAL_DIGITS, 8, number of BCD digits produced (>=1)
SIGNED_MODE, 1, 1 = i_bin is two's complement; 0 = unsigned

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
i_bin  input  INPUT_WIDTH  binary operand
i_valid  input  1  operand valid
o_ready  output  1  converter can accept (high only in IDLE)
o_bcd  output  DECIMAL_DIGITS*4  result, digit 0 in bits [3:0]
o_sign  output  1  1 = negative result
o_ovf  output  1  magnitude >= 10^DECIMAL_DIGITS; o_bcd holds magnitude mod 10^DECIMAL_DIGITS
o_ndigits  output  $clog2(DECIMAL_DIGITS+1)  significant digit count (1 for zero)
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result

Behaviour:
- Reset (RST_N low, async):
  - State is IDLE.
  - o_bcd=0, o_sign=0, o_ovf=0, o_ndigits=0, o_valid=0.
  - o_ready=1 once RST_N is released.
  - Internal counters and magnitude register are 0.
- Reset mid-conversion aborts immediately; there is no partial output.
- States: IDLE, ABS, CONVERT, COUNT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: latch i_bin, clear BCD/ovf/sign, go to ABS.
- ABS, 1 cycle:
  - If SIGNED_MODE and i_bin[MSB]=1: sign=1, magnitude = two's-complement negate, held as INPUT_WIDTH-bit unsigned.
  - Most-negative input yields 2^(INPUT_WIDTH-1) with no overflow of the magnitude register.
  - Otherwise sign=0 and magnitude = i_bin.
  - Go to CONVERT with bit counter = 0.
- CONVERT, exactly INPUT_WIDTH cycles. Each cycle:
  - Every digit >4 gets +3 (all digits in parallel, before the shift).
  - Then {BCD, magnitude} shifts left by 1.
  - The bit shifted out of the BCD MSB ORs into the sticky ovf.
  - The counter increments; after the INPUT_WIDTH-th shift go to COUNT.
  - The add-3 step is applied before every shift, including the first; the first adjust is harmless because BCD=0.
- COUNT, exactly DECIMAL_DIGITS cycles:
  - Scan digits from the most-significant down.
  - ndigits = index+1 of the highest nonzero digit; 1 if all digits are zero.
  - If ovf=1, ndigits = DECIMAL_DIGITS.
  - Sign is forced to 0 when the magnitude is zero (no "-0").
- DONE:
  - o_valid=1; o_bcd, o_sign, o_ovf, o_ndigits are stable.
  - On i_ready, return to IDLE at the next edge with o_valid=0.
  - Outputs keep their last values in IDLE until the next accept.
- Latency: accept edge to o_valid high = 1+INPUT_WIDTH+DECIMAL_DIGITS clocks, fixed and data-independent. The defaults give 33.
- Throughput: o_ready=0 from ABS through DONE, so there is no accept while busy. A new accept is possible in the cycle after DONE exits, giving back-to-back operation with a 1-cycle IDLE gap.
- i_valid while busy is ignored. i_bin need only be stable in the accept cycle.
- i_ready is held low: DONE persists indefinitely and outputs must not change.
- SIGNED_MODE=0: o_sign is always 0, and the full INPUT_WIDTH range is unsigned.

Decomposition:
- Shared package bcd_pkg:
  - State encoding localparams.
  - Function bcd_adj3(digit) returning digit+3 if >4.
  - Function digits_width(D) = $clog2(D+1).
- Sub-module bcd_shift_stage (combinational):
  - Applies bcd_adj3 across all digits, then performs the 1-bit shift.
  - Outputs the next BCD, next magnitude and the carry-out bit.
- The top level holds the FSM, counters and handshake.

Test Plan:
- Defaults, i_bin=0 -> after 33 cycles o_valid=1, o_bcd=0x00000000, o_sign=0, o_ovf=0, o_ndigits=1.
- Defaults, i_bin=-1234 (0xFFFB2E) -> o_bcd=0x00001234, o_sign=1, o_ndigits=4.
- Defaults, i_bin=0x800000 -> o_bcd=0x08388608, o_sign=1, o_ovf=0, o_ndigits=7.
- DECIMAL_DIGITS=6, i_bin=1234567 -> o_bcd=0x234567, o_ovf=1, o_ndigits=6, o_sign=0.
- SIGNED_MODE=0, i_bin=0xFFFFFF -> o_bcd=0x16777215, o_sign=0, o_ndigits=8. Then hold i_ready=0 for 20 cycles -> outputs stable and o_ready=0; raise i_ready -> o_valid drops next edge and o_ready=1.
- Drive RST_N low 10 cycles after accept -> all outputs 0 immediately. Release RST_N, then accept i_bin=42 -> o_bcd=0x00000042 after 33 cycles. Run back-to-back 99 and -7 -> both correct, each preceded by an o_ready pulse.
